// File: rtl/bist_engine.sv
// bist_engine: self-test controller for one scan-inserted UUT.
// An LFSR generates the patterns and a scan sequencer drives them through the chain.
// A MISR compacts the UUT responses, and the final signature is compared against GOLDEN.
module bist_engine #(
    parameter int                 IN_W      = 4,
    parameter int                 OUT_W     = 4,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter int                 SIG_W     = 8,
    parameter logic [SIG_W-1:0]   MISR_TAPS = 8'hB8,
    parameter int                 CHAIN_LEN = 8,
    parameter int                 PATTERNS  = 16,
    parameter logic [SIG_W-1:0]   GOLDEN    = 8'h27,
    localparam int                CNT_W     = $clog2(PATTERNS + 1),
    localparam int                SH_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               bist_start,
    input  logic [LFSR_W-1:0]  lfsr_seed,
    input  logic [IN_W-1:0]    func_in,
    output logic [IN_W-1:0]    uut_in,
    input  logic [OUT_W-1:0]   uut_out,
    output logic               scan_en,
    output logic               scan_in,
    input  logic               scan_out,
    output logic               bist_running,
    output logic               bist_end,
    output logic [SIG_W-1:0]   signature,
    output logic               pass_fail,
    output logic [CNT_W-1:0]   pattern_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_UNLOAD  = 3'd4,
        ST_COMPARE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS);

    // Fibonacci LFSR step: shift left, feed back the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    // MISR step: LFSR-style shift with the parallel response folded in.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] v,
                                                   input logic [SIG_W-1:0] resp);
        return {v[SIG_W-2:0], ^(v & MISR_TAPS)} ^ resp;
    endfunction

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [SIG_W-1:0]   misr_q, misr_d;
    logic [SH_W-1:0]    shcnt_q, shcnt_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic               pass_q, pass_d;
    logic               scan_en_q, running_q, end_q;
    logic [SIG_W-1:0]   resp_s;
    logic [CNT_W-1:0]   pcnt_inc_s;

    assign resp_s     = SIG_W'({uut_out, scan_out});
    assign pcnt_inc_s = pcnt_q + CNT_W'(1);

    // Next-state and datapath: every register holds unless the current state says otherwise.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        shcnt_d = shcnt_q;
        pcnt_d  = pcnt_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (bist_start) begin
                    state_d = ST_SEED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEED: begin
                // An all-zero seed would lock the LFSR, so it is replaced by 1.
                lfsr_d  = (lfsr_seed == {LFSR_W{1'b0}}) ? LFSR_W'(1) : lfsr_seed;
                misr_d  = {SIG_W{1'b0}};
                shcnt_d = {SH_W{1'b0}};
                pcnt_d  = {CNT_W{1'b0}};
                pass_d  = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                lfsr_d = lfsr_step(lfsr_q);
                misr_d = misr_step(misr_q, resp_s);
                if (shcnt_q == SH_LAST) begin
                    shcnt_d = {SH_W{1'b0}};
                    state_d = ST_CAPTURE;
                end else begin
                    shcnt_d = shcnt_q + SH_W'(1);
                end
            end
            ST_CAPTURE: begin
                lfsr_d  = lfsr_step(lfsr_q);
                misr_d  = misr_step(misr_q, resp_s);
                pcnt_d  = pcnt_inc_s;
                shcnt_d = {SH_W{1'b0}};
                if (pcnt_inc_s == CNT_LAST) begin
                    state_d = ST_UNLOAD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_UNLOAD: begin
                lfsr_d = lfsr_step(lfsr_q);
                misr_d = misr_step(misr_q, resp_s);
                if (shcnt_q == SH_LAST) begin
                    shcnt_d = {SH_W{1'b0}};
                    state_d = ST_COMPARE;
                end else begin
                    shcnt_d = shcnt_q + SH_W'(1);
                end
            end
            ST_COMPARE: begin
                pass_d  = (misr_q == GOLDEN);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bist_start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and decoded status flags; reset aborts any run in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_W'(1);
            misr_q    <= {SIG_W{1'b0}};
            shcnt_q   <= {SH_W{1'b0}};
            pcnt_q    <= {CNT_W{1'b0}};
            pass_q    <= 1'b0;
            scan_en_q <= 1'b0;
            running_q <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            shcnt_q   <= shcnt_d;
            pcnt_q    <= pcnt_d;
            pass_q    <= pass_d;
            scan_en_q <= (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
            running_q <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            end_q     <= (state_d == ST_DONE);
        end
    end

    assign scan_en      = scan_en_q;
    assign bist_running = running_q;
    assign bist_end     = end_q;
    assign signature    = misr_q;
    assign pass_fail    = pass_q;
    assign pattern_cnt  = pcnt_q;
    assign scan_in      = lfsr_q[LFSR_W-1];
    assign uut_in       = running_q ? lfsr_q[IN_W-1:0] : func_in;

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: default instance with a shift-register stub UUT,
// plus a CHAIN_LEN=1 / PATTERNS=1 instance driven with constant responses.
module tb_bist_engine;

    localparam int P = 16;
    localparam int C = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bist_start = 1'b0;
    logic [15:0] lfsr_seed = 16'h0000;
    logic [3:0]  func_in = 4'h0;
    logic [3:0]  uut_in;
    logic [3:0]  uut_out;
    logic        scan_en, scan_in, scan_out;
    logic        bist_running, bist_end, pass_fail;
    logic [7:0]  signature;
    logic [4:0]  pattern_cnt;

    logic        bist_start_s = 1'b0;
    logic [3:0]  uut_in_s;
    logic [3:0]  uut_out_s = 4'h0;
    logic        scan_en_s, scan_in_s;
    logic        scan_out_s = 1'b0;
    logic        bist_running_s, bist_end_s, pass_fail_s;
    logic [7:0]  signature_s;
    logic [0:0]  pattern_cnt_s;

    int total_checks = 0;
    int passed_checks = 0;

    always #5 clock = ~clock;

    bist_engine dut (
        .clock(clock), .reset(reset), .bist_start(bist_start), .lfsr_seed(lfsr_seed),
        .func_in(func_in), .uut_in(uut_in), .uut_out(uut_out), .scan_en(scan_en),
        .scan_in(scan_in), .scan_out(scan_out), .bist_running(bist_running),
        .bist_end(bist_end), .signature(signature), .pass_fail(pass_fail),
        .pattern_cnt(pattern_cnt)
    );

    bist_engine #(.CHAIN_LEN(1), .PATTERNS(1), .GOLDEN(8'h07)) dut_s (
        .clock(clock), .reset(reset), .bist_start(bist_start_s), .lfsr_seed(lfsr_seed),
        .func_in(func_in), .uut_in(uut_in_s), .uut_out(uut_out_s), .scan_en(scan_en_s),
        .scan_in(scan_in_s), .scan_out(scan_out_s), .bist_running(bist_running_s),
        .bist_end(bist_end_s), .signature(signature_s), .pass_fail(pass_fail_s),
        .pattern_cnt(pattern_cnt_s)
    );

    // Stub UUT: 8-bit scan chain, cleared on SEED; capture XORs uut_in into the low nibble.
    logic [7:0] chain_q = 8'h00;
    logic       prev_run = 1'b0;
    logic       fault = 1'b0;
    logic [7:0] mask_s;
    assign mask_s   = fault ? 8'hFB : 8'hFF;
    assign uut_out  = chain_q[3:0];
    assign scan_out = chain_q[7];

    always @(posedge clock) begin
        prev_run <= bist_running;
        if (bist_running && !prev_run) chain_q <= 8'h00;
        else if (bist_running && scan_en) chain_q <= {chain_q[6:0], scan_in} & mask_s;
        else if (bist_running) chain_q <= (chain_q ^ {4'h0, uut_in}) & mask_s;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference: walk the test schedule (P loads of C shifts + capture, then C unload shifts).
    function automatic logic [7:0] model_sig(input logic [15:0] seed, input logic flt);
        logic [15:0] lf;
        logic [7:0]  m, ch, mk;
        logic        sh;
        lf = (seed == 16'h0000) ? 16'h0001 : seed;
        m  = 8'h00;
        ch = 8'h00;
        mk = flt ? 8'hFB : 8'hFF;
        for (int i = 0; i < P*(C+1) + C; i++) begin
            sh = (i >= P*(C+1)) || ((i % (C+1)) != C);
            m  = {m[6:0], ^(m & 8'hB8)} ^ {3'b000, ch[3:0], ch[7]};
            if (sh) ch = {ch[6:0], lf[15]} & mk;
            else    ch = (ch ^ {4'h0, lf[3:0]}) & mk;
            lf = {lf[14:0], ^(lf & 16'hB400)};
        end
        return m;
    endfunction

    function automatic logic exp_scan_en(input int n);
        if (n >= 1 && n <= P*(C+1)) return ((n-1) % (C+1)) != C;
        if (n > P*(C+1) && n <= P*(C+1) + C) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_default(input logic [15:0] seed, input logic flt, input string tag);
        logic [7:0]  exp_sig;
        logic [15:0] lf;
        logic [7:0]  held_sig;
        logic        prev_se, seen0, seen1, held_pass;
        int n, done_n, se_err, run_err, cnt_err, str_err, rises, highs, hold_err, exp_cnt;
        exp_sig = model_sig(seed, flt);
        fault = flt;
        lfsr_seed = seed;
        lf = (seed == 16'h0000) ? 16'h0001 : seed;
        done_n = -1; n = 0; se_err = 0; run_err = 0; cnt_err = 0; str_err = 0;
        rises = 0; highs = 0; prev_se = 1'b0; seen0 = 1'b0; seen1 = 1'b0;
        @(negedge clock);
        bist_start = 1'b1;
        while (done_n < 0 && n < 400) begin
            @(negedge clock);
            if (bist_end) begin
                done_n = n;
            end else begin
                if (scan_en !== exp_scan_en(n)) se_err++;
                if (bist_running !== 1'b1) run_err++;
                if (n >= 1) begin
                    exp_cnt = (n - 1) / (C + 1);
                    if (exp_cnt > P) exp_cnt = P;
                    if (pattern_cnt !== 5'(exp_cnt)) cnt_err++;
                    if (scan_in !== lf[15] || uut_in !== lf[3:0]) str_err++;
                    if (scan_in) seen1 = 1'b1; else seen0 = 1'b1;
                    lf = {lf[14:0], ^(lf & 16'hB400)};
                end
                if (scan_en && !prev_se) rises++;
                if (scan_en) highs++;
                prev_se = scan_en;
                n++;
            end
        end
        chk({tag, "_latency"}, done_n, 154);
        chk({tag, "_scan_en_sched"}, se_err, 0);
        chk({tag, "_scan_en_runs"}, rises, P + 1);
        chk({tag, "_scan_en_highs"}, highs, (P + 1) * C);
        chk({tag, "_running"}, run_err, 0);
        chk({tag, "_pattern_cnt_trace"}, cnt_err, 0);
        chk({tag, "_lfsr_stream"}, str_err, 0);
        chk({tag, "_scan_in_toggles"}, {seen0, seen1}, 2'b11);
        chk({tag, "_pattern_cnt_final"}, pattern_cnt, P);
        chk({tag, "_signature"}, signature, exp_sig);
        chk({tag, "_pass_fail"}, pass_fail, exp_sig == 8'h27);
        held_sig = exp_sig;
        held_pass = (exp_sig == 8'h27);
        hold_err = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bist_end !== 1'b1 || signature !== held_sig || bist_running !== 1'b0) hold_err++;
        end
        chk({tag, "_done_hold"}, hold_err, 0);
        bist_start = 1'b0;
        @(negedge clock);
        chk({tag, "_end_drop"}, {bist_end, bist_running}, 2'b00);
        chk({tag, "_pass_hold_idle"}, pass_fail, held_pass);
        chk({tag, "_sig_hold_idle"}, signature, held_sig);
        fault = 1'b0;
    endtask

    typedef struct {
        logic [3:0] fi;
        logic [3:0] exp_ui;
    } pt_vec_t;

    typedef struct {
        logic [15:0] seed;
        logic        flt;
    } run_vec_t;

    pt_vec_t    pt_tab[4];
    run_vec_t   run_tab[6];
    logic [7:0] s_ref, s_flt, exp_small;
    logic [4:0] resp_small;
    int         done_s, run_err_s;

    initial begin
        pt_tab[0] = '{4'hA, 4'hA};
        pt_tab[1] = '{4'h5, 4'h5};
        pt_tab[2] = '{4'h0, 4'h0};
        pt_tab[3] = '{4'hF, 4'hF};
        run_tab[0] = '{16'hACE1, 1'b0};
        run_tab[1] = '{16'hACE1, 1'b0};
        run_tab[2] = '{16'hACE1, 1'b1};
        run_tab[3] = '{16'h0000, 1'b0};
        run_tab[4] = '{16'($urandom), 1'b0};
        run_tab[5] = '{16'($urandom), 1'b0};

        // Reset values
        func_in = 4'h3;
        #12;
        chk("rst_outputs", {scan_en, bist_running, bist_end, pass_fail}, 4'b0000);
        chk("rst_pattern_cnt", pattern_cnt, 0);
        chk("rst_signature", signature, 8'h00);
        chk("rst_scan_in", scan_in, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Functional pass-through with bist_start low
        for (int i = 0; i < 4; i++) begin
            func_in = pt_tab[i].fi;
            @(negedge clock);
            chk("func_uut_in", uut_in, pt_tab[i].exp_ui);
            chk("func_status", {scan_en, bist_running}, 2'b00);
        end

        // Abort during SHIFT of pattern 3, then a clean full run
        lfsr_seed = 16'hACE1;
        @(negedge clock);
        bist_start = 1'b1;
        for (int n = 0; n <= 22; n++) @(negedge clock);
        chk("abort_in_shift_p3", {scan_en, pattern_cnt}, {1'b1, 5'd2});
        reset = 1'b1;
        bist_start = 1'b0;
        #1;
        chk("abort_outputs", {scan_en, bist_running, bist_end, pass_fail}, 4'b0000);
        chk("abort_cnt_sig", {pattern_cnt, signature}, 13'h0);
        @(negedge clock);
        reset = 1'b0;
        run_default(16'hACE1, 1'b0, "post_abort");

        // Table of full runs checked against the reference model
        s_ref = model_sig(16'hACE1, 1'b0);
        s_flt = model_sig(16'hACE1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_default(run_tab[i].seed, run_tab[i].flt, $sformatf("run%0d", i));
            if (run_tab[i].flt) chk("fault_sig_differs", signature != s_ref, s_flt != s_ref);
            else if (run_tab[i].seed == 16'hACE1) chk("repeat_sig_same", signature, s_ref);
        end

        // Small instance: constant response, bist_start pulsed mid-run
        lfsr_seed = 16'h8001;
        for (int r = 0; r < 2; r++) begin
            resp_small = (r == 0) ? 5'h01 : 5'h12;
            {uut_out_s, scan_out_s} = resp_small;
            exp_small = 8'h00;
            for (int k = 0; k < 3; k++)
                exp_small = {exp_small[6:0], ^(exp_small & 8'hB8)} ^ {3'b000, resp_small};
            done_s = -1;
            run_err_s = 0;
            @(negedge clock);
            bist_start_s = 1'b1;
            for (int n = 0; n < 9; n++) begin
                @(negedge clock);
                if (n == 1) begin
                    chk("small_shift", {scan_en_s, scan_in_s}, 2'b11);
                end
                if (n <= 4 && bist_running_s !== 1'b1) run_err_s++;
                if (bist_end_s && done_s < 0) begin
                    done_s = n;
                    chk("small_sig", signature_s, exp_small);
                    chk("small_pass", pass_fail_s, exp_small == 8'h07);
                    chk("small_cnt", pattern_cnt_s, 1'b1);
                end
                if (n == 6) begin
                    chk("small_idle", {bist_end_s, bist_running_s, uut_in_s}, {2'b00, func_in});
                    chk("small_pass_hold", pass_fail_s, exp_small == 8'h07);
                end
                if (n == 1) bist_start_s = 1'b0;
                if (n == 2) bist_start_s = 1'b1;
                if (n == 3) bist_start_s = 1'b0;
            end
            chk("small_latency", done_s, 5);
            chk("small_running", run_err_s, 0);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/bist_engine.md
Name: bist_engine

Overview:
Parametrised self-test engine for one scan-inserted UUT. It combines pattern generation (LFSR), scan sequencing, input muxing, response compaction (MISR) and golden-signature comparison in a single block. It sits between chip pins and the UUT: it drives the UUT inputs, scan_en and scan_in, and observes the UUT outputs and scan_out. Compared with the previous generation, widths, chain length and pattern count are generic, and pass/fail is an exact signature compare.

Parameters:
IN_W, 4, UUT primary-input width
OUT_W, 4, UUT primary-output width
LFSR_W, 16, pattern LFSR width; must be >= IN_W+1
LFSR_TAPS, 16'hB400, Fibonacci feedback tap mask
SIG_W, 8, MISR width; must be >= OUT_W+1
MISR_TAPS, 8'hB8, MISR feedback tap mask
CHAIN_LEN, 8, UUT scan-chain length (>=1)
PATTERNS, 16, number of scan-load/capture patterns (>=1)
GOLDEN, 8'h27, expected final signature

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
bist_start  in  1  level request, sampled in IDLE
lfsr_seed  in  LFSR_W  LFSR seed, sampled in SEED
func_in  in  IN_W  functional inputs, passed through when not running
uut_in  out  IN_W  UUT primary inputs
uut_out  in  OUT_W  UUT primary outputs
scan_en  out  1  UUT scan enable
scan_in  out  1  serial data into UUT chain
scan_out  in  1  serial data from UUT chain
bist_running  out  1  high from SEED through COMPARE
bist_end  out  1  high in DONE
signature  out  SIG_W  current MISR value
pass_fail  out  1  1 = signature matched GOLDEN (valid when bist_end=1)
pattern_cnt  out  clog2(PATTERNS+1)  patterns captured so far

Behaviour:
- Reset: FSM=IDLE; LFSR=1; MISR=0; counters=0. Outputs: scan_en=0, bist_running=0, bist_end=0, pass_fail=0, pattern_cnt=0, signature=0.
- Reset mid-run aborts the test immediately, with no partial result.
- FSM states: IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE: if bist_start=1, go to SEED.
- SEED (1 cycle):
  - LFSR <= lfsr_seed; an all-zero seed loads 1.
  - MISR <= 0; shift_cnt <= 0; pattern_cnt <= 0.
  - Go to SHIFT.
- SHIFT (CHAIN_LEN cycles): scan_en=1. Then go to CAPTURE.
- CAPTURE (1 cycle): scan_en=0; pattern_cnt++.
  - If the new pattern_cnt==PATTERNS, go to UNLOAD; otherwise go to SHIFT (shift_cnt cleared).
- UNLOAD (CHAIN_LEN cycles): scan_en=1; flushes the last capture. Then go to COMPARE.
- COMPARE (1 cycle): pass_fail <= (MISR == GOLDEN), using the MISR value after the last UNLOAD update. Go to DONE.
- DONE: bist_end=1; signature and pass_fail are held.
  - Stay until bist_start=0, then go to IDLE; bist_end drops and pass_fail holds until the next SEED.
- bist_start is ignored outside IDLE and DONE.
- Total latency: from the first SEED cycle to the first DONE cycle is 1 + PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles (154 with defaults).
- LFSR:
  - Advances in SHIFT, CAPTURE and UNLOAD: next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}. Frozen in other states.
  - scan_in = lfsr[LFSR_W-1], combinational.
  - uut_in = bist_running ? lfsr[IN_W-1:0] : func_in, combinational.
- MISR:
  - Updates in SHIFT, CAPTURE and UNLOAD: next = {misr[SIG_W-2:0], ^(misr & MISR_TAPS)} XOR zero-extend({uut_out, scan_out}).
  - Frozen otherwise; cleared only in SEED or on reset.
- Fully deterministic: same seed and same UUT give a bit-identical signature.

Test Plan:
1. Reset during SHIFT of pattern 3 -> next cycle all outputs at reset values; a new bist_start gives a full 154-cycle run.
2. Functional mode: bist_start=0, func_in=4'hA -> uut_in=4'hA, scan_en=0, bist_running=0 every cycle.
3. Default run, bist_start held high, seed 16'hACE1:
   - scan_en high for exactly 17 runs of 8 cycles, separated by 16 single-cycle lows.
   - pattern_cnt reaches 16; bist_end rises 154 cycles after SEED.
   - bist_end stays high until bist_start falls.
4. Golden match, against a stub UUT of a CHAIN_LEN shift register with uut_out = chain[3:0]:
   - Run once with seed 16'hACE1 and record signature S.
   - Rerun with GOLDEN=S -> pass_fail=1 and identical S.
   - Flip one stub chain bit (stuck-at-0) -> pass_fail=0 and signature != S.
5. Zero seed 16'h0000 -> LFSR loads 1; scan_in not constant over the run; completion timing matches scenario 3.
6. Parameter sweep CHAIN_LEN=1, PATTERNS=1 -> DONE at cycle 1+2+1+1=5; bist_start pulsed mid-run has no effect.
